// File: rtl/mult_div.sv
// mult_div: iterative signed 32x16 multiply / 32/16 divide unit.
// One operation in flight; results and exception are held until the next completion.
module mult_div (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic [31:0] data_operandA,
  input  logic [15:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_inputRDY,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [31:0] opa_q, opa_d;      // multiplicand, or |dividend| shift register
  logic [15:0] opb_q, opb_d;      // multiplier, or |divisor|
  logic [47:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  // Operand magnitudes; -2^31 maps to 0x80000000, which is exact as unsigned.
  logic [31:0] a_abs;
  logic [15:0] b_abs;

  always_comb begin
    a_abs = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_abs = data_operandB[15] ? (~data_operandB + 16'd1) : data_operandB;
  end

  // Multiply iteration: iteration 0 adds A * unsigned B[7:0], iteration 1 adds
  // (A * signed B[15:8]) << 8, giving the exact 48-bit signed product.
  logic [8:0]         slice9;
  logic signed [40:0] mul_a41, mul_s41, pp;
  logic [47:0]        pp48, pp_shift, mac;
  logic               mul_ovf;

  always_comb begin
    slice9   = cnt_q[0] ? {opb_q[15], opb_q[15:8]} : {1'b0, opb_q[7:0]};
    mul_a41  = {{9{opa_q[31]}}, opa_q};
    mul_s41  = {{32{slice9[8]}}, slice9};
    pp       = mul_a41 * mul_s41;
    pp48     = {{7{pp[40]}}, pp};
    pp_shift = cnt_q[0] ? {pp48[39:0], 8'd0} : pp48;
    mac      = acc_q + pp_shift;
    mul_ovf  = ~((&mac[47:31]) | ~(|mac[47:31]));
  end

  // Divide iteration: four unrolled restoring shift-subtract steps, MSB first.
  logic [31:0] rem_w, dvd_w, q_w, quo_fin;

  always_comb begin
    rem_w = rem_q;
    dvd_w = opa_q;
    q_w   = quo_q;
    for (int unsigned i = 0; i < 4; i++) begin
      rem_w = {rem_w[30:0], dvd_w[31]};
      dvd_w = {dvd_w[30:0], 1'b0};
      if (rem_w >= {16'd0, opb_q}) begin
        rem_w = rem_w - {16'd0, opb_q};
        q_w   = {q_w[30:0], 1'b1};
      end else begin
        q_w   = {q_w[30:0], 1'b0};
      end
    end
    quo_fin = sign_q ? (~q_w + 32'd1) : q_w;
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE, DONE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          sign_d = data_operandA[31] ^ data_operandB[15];
          cnt_d  = '0;
          if (ctrl_MULT) begin
            state_d = MUL;
            opa_d   = data_operandA;
            opb_d   = data_operandB;
            acc_d   = '0;
          end else begin
            state_d = DIV;
            opa_d   = a_abs;
            opb_d   = b_abs;
            rem_d   = '0;
            quo_d   = '0;
          end
        end
      end
      MUL: begin
        acc_d = mac;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q[0]) begin
          result_d = mac[31:0];
          exc_d    = mul_ovf | (mac[31] ^ sign_q);
          state_d  = DONE;
        end
      end
      DIV: begin
        if (opb_q == '0) begin
          result_d = '0;
          exc_d    = 1'b1;
          state_d  = DONE;
        end else begin
          opa_d = dvd_w;
          rem_d = rem_w;
          quo_d = q_w;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            result_d = quo_fin;
            exc_d    = quo_fin[31] ^ sign_q;
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    data_result    = result_q;
    data_exception = exc_q;
    data_inputRDY  = (state_q == IDLE) || (state_q == DONE);
    data_resultRDY = (state_q == DONE);
  end

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: driver pushes model results, monitor pops on resultRDY rise.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic [31:0] data_operandA;
  logic [15:0] data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_inputRDY, data_resultRDY;

  always #5 clock = ~clock;

  mult_div dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_inputRDY (data_inputRDY),
    .data_resultRDY(data_resultRDY)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        mon_prev = 1'b0;
  logic [31:0] hold_res = '0;
  logic        hold_exc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the signed operands.
  task automatic model(input logic mul, input logic [31:0] a, input logic [15:0] b,
                       output logic [31:0] r, output logic e, output int lat);
    longint sa, sbv, p;
    logic   s;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    s   = a[31] ^ b[15];
    if (mul) begin
      p   = sa * sbv;
      r   = p[31:0];
      e   = (p > 64'sd2147483647) || (p < -64'sd2147483648) || (r[31] != s);
      lat = 2;
    end else if (b == 16'd0) begin
      r   = '0;
      e   = 1'b1;
      lat = 1;
    end else begin
      p   = sa / sbv;
      r   = p[31:0];
      e   = (r[31] != s);
      lat = 8;
    end
  endtask

  // Monitor: every rising data_resultRDY consumes one expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (data_resultRDY && !mon_prev) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got 0x%08h with no pending request, want none", data_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_result"}, data_result, e.res);
          check({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
        end
      end
      mon_prev = data_resultRDY;
    end
  end

  // Driver: issue at a negedge, hold the request until the result is seen.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [15:0] b, input string name);
    exp_t        e;
    logic [31:0] r;
    logic        x;
    int          lat, k;
    model(m, a, b, r, x, lat);
    e.res = r; e.exc = x; e.name = name;
    sb.push_back(e);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        check({name, "_busy_inrdy"}, {31'd0, data_inputRDY}, 32'd0);
        check({name, "_held_result"}, data_result, hold_res);
      end
    end while (!data_resultRDY && k < 40);
    if (!data_resultRDY) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no resultRDY in %0d cycles, want %0d", name, k, lat);
    end else begin
      check({name, "_latency"}, k - 1, lat);
    end
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    hold_res  = r;
    hold_exc  = x;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    ctrl_reset_n  = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'd0, data_exception}, 32'd0);
    check("reset_inrdy", {31'd0, data_inputRDY}, 32'd1);
    check("reset_resrdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(negedge clock);

    run_op(1'b1, 1'b0, 32'd7, 16'hFFFD, "mul_7x-3");
    run_op(1'b1, 1'b0, 32'h40000000, 16'd4, "mul_ovf");
    run_op(1'b1, 1'b0, 32'd65536, 16'd32767, "mul_max");
    run_op(1'b0, 1'b1, 32'd100, 16'hFFF9, "div_100/-7");
    run_op(1'b0, 1'b1, 32'hFFFFFF9C, 16'd7, "div_-100/7");
    run_op(1'b1, 1'b1, 32'd6, 16'd7, "both_high");
    run_op(1'b0, 1'b1, 32'd12345, 16'd0, "div_by_zero");
    run_op(1'b0, 1'b1, 32'h80000000, 16'hFFFF, "div_wrap");

    // Reset during the fourth divide iteration; no result is expected from it.
    data_operandA = 32'd1000000;
    data_operandB = 16'd3;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (3) @(negedge clock);
    ctrl_reset_n = 1'b0;
    #1;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exc", {31'd0, data_exception}, 32'd0);
    check("midreset_inrdy", {31'd0, data_inputRDY}, 32'd1);
    check("midreset_resrdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    hold_res = '0;
    hold_exc = 1'b0;
    @(negedge clock);
    run_op(1'b1, 1'b0, 32'd1000, 16'd1000, "mul_after_reset");

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [15:0] b;
      int          t;
      if ($urandom_range(0, 1) == 1) a = $urandom;
      else begin t = int'($urandom_range(0, 2000)) - 1000; a = 32'(t); end
      if ($urandom_range(0, 2) == 0) begin t = int'($urandom_range(0, 40)) - 20; b = 16'(t); end
      else b = 16'($urandom);
      run_op(1'b1, 1'b0, a, b, $sformatf("rnd%0d_mul", i));
      run_op(1'b0, 1'b1, a, b, $sformatf("rnd%0d_div", i));
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
